// File: rtl/mc_dbuf_pkg.sv
// Shared types and default sizing for the multi-channel sample buffer.
package mc_dbuf_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } dbuf_state_e;

  localparam int DBUF_DATA_W     = 16;
  localparam int DBUF_ADDR_W     = 8;
  localparam int DBUF_NUM_CH     = 2;
  localparam int DBUF_ZERO_LIMIT = 800;

endpackage

// File: rtl/dbuf_bank.sv
// Single-channel sample bank: one write port, registered read that returns the
// pre-write contents when reading and writing the same address.
module dbuf_bank
  import mc_dbuf_pkg::*;
#(
  parameter int DATA_W = DBUF_DATA_W,
  parameter int ADDR_W = DBUF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // No reset on the array: contents are scrubbed by a clear sweep instead.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mc_data_buffer.sv
// Multi-channel circular sample buffer with age-indexed reads, clear sweep FSM
// and an optional per-channel sustained-zero detector (MC_DBUF_ZERO_DETECT_EN).
//
// state | meaning
// IDLE  | normal operation, writes and reads served from the banks
// CLEAR | zeroing one address per cycle in all banks; writes dropped
module mc_data_buffer
  import mc_dbuf_pkg::*;
#(
  parameter int DATA_W     = DBUF_DATA_W,
  parameter int ADDR_W     = DBUF_ADDR_W,
  parameter int NUM_CH     = DBUF_NUM_CH,
  parameter int ZERO_LIMIT = DBUF_ZERO_LIMIT,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              Sclk,
  input  logic              Reset_n,
  input  logic              clr_req,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [DATA_W-1:0] data_in,
  input  logic              rd_en,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [ADDR_W-1:0] rd_offset,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              wr_drop,
  output logic [NUM_CH-1:0] zero_flag
);

  localparam int DEPTH = 2**ADDR_W;

  dbuf_state_e       state_q, state_d;
  logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
  logic              clr_start;
  logic              wr_ch_ok, rd_ch_ok, wr_acc;
  logic [ADDR_W-1:0] wr_ptr_q [NUM_CH];
  logic [ADDR_W-1:0] wr_ptr_d [NUM_CH];
  logic [DATA_W-1:0] bank_rdata [NUM_CH];
  logic              rd_valid_q, rd_zero_q, wr_drop_q;
  logic [CH_W-1:0]   rd_ch_q;

  assign busy     = (state_q == CLEAR);
  assign wr_ch_ok = int'(wr_ch) < NUM_CH;
  assign rd_ch_ok = int'(rd_ch) < NUM_CH;
  assign wr_acc   = wr_en && !busy && wr_ch_ok;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    clr_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d    = CLEAR;
          clr_addr_d = '0;
          clr_start  = 1'b1;
        end
      end
      CLEAR: begin
        if (clr_req) begin
          clr_addr_d = '0;
          clr_start  = 1'b1;
        end else if (clr_addr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end else begin
          clr_addr_d = clr_addr_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      wr_ptr_d[k] = wr_ptr_q[k];
      if (clr_start) wr_ptr_d[k] = '0;
      else if (wr_acc && int'(wr_ch) == k) wr_ptr_d[k] = wr_ptr_q[k] + ADDR_W'(1);
    end
  end

  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      clr_addr_q <= '0;
      rd_valid_q <= 1'b0;
      rd_zero_q  <= 1'b0;
      rd_ch_q    <= '0;
      wr_drop_q  <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) wr_ptr_q[k] <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
      rd_valid_q <= rd_en;
      rd_zero_q  <= busy || !rd_ch_ok;
      rd_ch_q    <= rd_ch;
      wr_drop_q  <= wr_en && (busy || !wr_ch_ok);
      for (int k = 0; k < NUM_CH; k++) wr_ptr_q[k] <= wr_ptr_d[k];
    end
  end

  // Read address is computed per bank from its own pointer, so an
  // out-of-range rd_ch never indexes past the pointer array.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_bank
    logic              bank_we;
    logic [ADDR_W-1:0] bank_waddr, bank_raddr;
    logic [DATA_W-1:0] bank_wdata;

    assign bank_we    = busy || (wr_acc && int'(wr_ch) == k);
    assign bank_waddr = busy ? clr_addr_q : wr_ptr_q[k];
    assign bank_wdata = busy ? '0 : data_in;
    assign bank_raddr = wr_ptr_q[k] - ADDR_W'(1) - rd_offset;

    dbuf_bank #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_bank (
      .clk_i   (Sclk),
      .we_i    (bank_we),
      .waddr_i (bank_waddr),
      .wdata_i (bank_wdata),
      .raddr_i (bank_raddr),
      .rdata_o (bank_rdata[k])
    );
  end

  assign rd_data  = (rd_valid_q && !rd_zero_q) ? bank_rdata[rd_ch_q] : '0;
  assign rd_valid = rd_valid_q;
  assign wr_drop  = wr_drop_q;

`ifdef MC_DBUF_ZERO_DETECT_EN
  localparam int CNT_W = $clog2(ZERO_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(ZERO_LIMIT);

  logic [CNT_W-1:0]  zero_cnt_q [NUM_CH];
  logic [CNT_W-1:0]  zero_cnt_d [NUM_CH];
  logic [NUM_CH-1:0] zero_flag_q, zero_flag_d;

  always_comb begin
    zero_flag_d = zero_flag_q;
    for (int k = 0; k < NUM_CH; k++) begin
      zero_cnt_d[k] = zero_cnt_q[k];
      if (wr_acc && int'(wr_ch) == k) begin
        if (data_in == '0) begin
          if (zero_cnt_q[k] != LIMIT) zero_cnt_d[k] = zero_cnt_q[k] + CNT_W'(1);
          zero_flag_d[k] = (zero_cnt_d[k] == LIMIT);
        end else begin
          zero_cnt_d[k]  = '0;
          zero_flag_d[k] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge Sclk or negedge Reset_n) begin
    if (!Reset_n) begin
      zero_flag_q <= '0;
      for (int k = 0; k < NUM_CH; k++) zero_cnt_q[k] <= '0;
    end else begin
      zero_flag_q <= zero_flag_d;
      for (int k = 0; k < NUM_CH; k++) zero_cnt_q[k] <= zero_cnt_d[k];
    end
  end

  assign zero_flag = zero_flag_q;
`else
  assign zero_flag = '0;
`endif

endmodule

// File: tb/tb_mc_data_buffer.sv
// Bench for mc_data_buffer: directed vector table, corner sequences and random
// traffic checked against a cycle model built from arrays and counters.
module tb_mc_data_buffer;

  localparam int DEPTH = 256;
  localparam int LIMIT = 800;
`ifdef MC_DBUF_ZERO_DETECT_EN
  localparam bit ZD = 1'b1;
`else
  localparam bit ZD = 1'b0;
`endif

  logic        Sclk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        clr_req = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [0:0]  wr_ch = '0, rd_ch = '0;
  logic [15:0] data_in = '0;
  logic [7:0]  rd_offset = '0;
  logic [15:0] rd_data;
  logic        rd_valid, busy, wr_drop;
  logic [1:0]  zero_flag;

  mc_data_buffer dut (
    .Sclk(Sclk), .Reset_n(Reset_n), .clr_req(clr_req), .wr_en(wr_en),
    .wr_ch(wr_ch), .data_in(data_in), .rd_en(rd_en), .rd_ch(rd_ch),
    .rd_offset(rd_offset), .rd_data(rd_data), .rd_valid(rd_valid),
    .busy(busy), .wr_drop(wr_drop), .zero_flag(zero_flag)
  );

  always #5 Sclk = ~Sclk;

  int n_checks = 0;
  int n_err = 0;

  // Reference model: sample arrays, pointers, zero run lengths, sweep cycles left.
  bit [15:0] m_mem [2][DEPTH];
  int        m_wptr [2];
  int        m_zcnt [2];
  bit        m_zflag [2];
  int        m_clr_left;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_wptr[c] = 0; m_zcnt[c] = 0; m_zflag[c] = 0;
    end
    m_clr_left = 0;
  endtask

  task automatic step(input bit we, input bit wc, input logic [15:0] d, input bit re,
                      input bit rc, input logic [7:0] off, input bit clr);
    bit          busy_pre, e_valid, e_drop;
    logic [15:0] e_data;
    busy_pre = m_clr_left > 0;
    wr_en = we; wr_ch = wc; data_in = d; rd_en = re; rd_ch = rc;
    rd_offset = off; clr_req = clr;
    e_valid = re;
    e_data  = (re && !busy_pre) ? m_mem[rc][(m_wptr[rc] + 2*DEPTH - 1 - int'(off)) % DEPTH] : 16'h0;
    e_drop  = we && busy_pre;
    if (busy_pre)
      for (int c = 0; c < 2; c++) m_mem[c][DEPTH - m_clr_left] = 16'h0;
    if (we && !busy_pre) begin
      m_mem[wc][m_wptr[wc]] = d;
      m_wptr[wc] = (m_wptr[wc] + 1) % DEPTH;
      if (d == 16'h0) begin
        if (m_zcnt[wc] < LIMIT) m_zcnt[wc]++;
        m_zflag[wc] = (m_zcnt[wc] == LIMIT);
      end else begin
        m_zcnt[wc] = 0; m_zflag[wc] = 0;
      end
    end
    if (clr) begin
      m_clr_left = DEPTH;
      m_wptr[0] = 0; m_wptr[1] = 0;
    end else if (busy_pre) begin
      m_clr_left--;
    end
    @(posedge Sclk); #1;
    chk("rd_valid", rd_valid, e_valid);
    chk("rd_data", rd_data, e_data);
    chk("busy", busy, m_clr_left > 0);
    chk("wr_drop", wr_drop, e_drop);
    chk("zero_flag", zero_flag, {m_zflag[1] & ZD, m_zflag[0] & ZD});
  endtask

  typedef struct {
    bit we; bit wc; logic [15:0] d; bit re; bit rc; logic [7:0] off;
    bit v; logic [15:0] x;
  } vec_t;

  function automatic vec_t mk(bit we, bit wc, logic [15:0] d, bit re, bit rc,
                              logic [7:0] off, bit v, logic [15:0] x);
    vec_t r;
    r.we = we; r.wc = wc; r.d = d; r.re = re; r.rc = rc; r.off = off; r.v = v; r.x = x;
    return r;
  endfunction

  vec_t tbl [14];
  int   busy_cnt, drops;

  initial begin
    tbl[0]  = mk(1, 0, 16'd1, 0, 0, 8'd0, 0, 16'd0);
    tbl[1]  = mk(1, 0, 16'd2, 0, 0, 8'd0, 0, 16'd0);
    tbl[2]  = mk(1, 0, 16'd3, 0, 0, 8'd0, 0, 16'd0);
    tbl[3]  = mk(1, 0, 16'd4, 0, 0, 8'd0, 0, 16'd0);
    tbl[4]  = mk(1, 0, 16'd5, 0, 0, 8'd0, 0, 16'd0);
    tbl[5]  = mk(0, 0, 16'd0, 1, 0, 8'd0, 1, 16'd5);
    tbl[6]  = mk(0, 0, 16'd0, 1, 0, 8'd1, 1, 16'd4);
    tbl[7]  = mk(0, 0, 16'd0, 1, 0, 8'd4, 1, 16'd1);
    tbl[8]  = mk(0, 0, 16'd0, 0, 0, 8'd0, 0, 16'd0);
    tbl[9]  = mk(1, 0, 16'd3, 0, 0, 8'd0, 0, 16'd0);
    tbl[10] = mk(1, 0, 16'd7, 1, 0, 8'd0, 1, 16'd3);
    tbl[11] = mk(0, 0, 16'd0, 1, 0, 8'd0, 1, 16'd7);
    tbl[12] = mk(0, 0, 16'd0, 1, 0, 8'd2, 1, 16'd5);
    tbl[13] = mk(0, 0, 16'd0, 1, 1, 8'd0, 1, 16'd0);

    model_reset();
    repeat (3) @(posedge Sclk);
    @(negedge Sclk); Reset_n = 1'b1; #1;
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_rd_data", rd_data, 0);
    chk("reset_busy", busy, 0);
    chk("reset_wr_drop", wr_drop, 0);
    chk("reset_zero_flag", zero_flag, 0);

    // Full clear sweep with two dropped writes inside it
    step(0, 0, 16'h0, 0, 0, 8'd0, 1);
    busy_cnt = int'(busy); drops = int'(wr_drop);
    for (int c = 1; c < 400 && busy; c++) begin
      step(c == 1 || c == 100, c[0], 16'h55, (c % 50) == 0, 0, c[7:0], 0);
      busy_cnt += int'(busy); drops += int'(wr_drop);
    end
    chk("clear_busy_cycles", busy_cnt, 256);
    chk("clear_drop_count", drops, 2);
    step(0, 0, 16'h0, 1, 0, 8'd0, 0);
    chk("after_clear_ch0", rd_data, 16'h0);
    step(0, 0, 16'h0, 1, 1, 8'd17, 0);
    chk("after_clear_ch1", rd_data, 16'h0);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].we, tbl[i].wc, tbl[i].d, tbl[i].re, tbl[i].rc, tbl[i].off, 0);
      chk($sformatf("tbl%0d_valid", i), rd_valid, tbl[i].v);
      chk($sformatf("tbl%0d_data", i), rd_data, tbl[i].x);
    end

    // Wrap: 260 writes into a 256-deep bank
    for (int i = 0; i < 260; i++) step(1, 1, i[15:0], 0, 0, 8'd0, 0);
    step(0, 0, 16'h0, 1, 1, 8'd0, 0);
    chk("wrap_off0", rd_data, 16'd259);
    step(0, 0, 16'h0, 1, 1, 8'd255, 0);
    chk("wrap_off255", rd_data, 16'd4);

    // Sustained zeros on ch0
    for (int i = 0; i < LIMIT; i++) begin
      step(1, 0, 16'h0, 0, 0, 8'd0, 0);
      if (i == LIMIT - 2) chk("zflag_before_limit", zero_flag[0], 0);
    end
    chk("zflag_at_limit", zero_flag[0], ZD);
    step(1, 0, 16'h0, 0, 0, 8'd0, 0);
    chk("zflag_saturated", zero_flag[0], ZD);
    chk("zflag_ch1_quiet", zero_flag[1], 0);
    step(1, 0, 16'h1, 0, 0, 8'd0, 0);
    chk("zflag_cleared", zero_flag[0], 0);

    for (int i = 0; i < 1500; i++)
      step($urandom_range(1), $urandom_range(1),
           ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom),
           $urandom_range(1), $urandom_range(1), 8'($urandom),
           $urandom_range(399) == 0);
    for (int i = 0; i < 300 && m_clr_left > 0; i++) step(0, 0, 16'h0, 0, 0, 8'd0, 0);
    chk("random_drained", busy, 0);

    // Reset in the middle of a sweep and of a zero run
    for (int i = 0; i < 400; i++) step(1, 0, 16'h0, 0, 0, 8'd0, 0);
    step(0, 0, 16'h0, 0, 0, 8'd0, 1);
    repeat (10) step(0, 0, 16'h0, 0, 0, 8'd0, 0);
    step(0, 0, 16'h0, 1, 0, 8'd0, 0);
    chk("pre_reset_busy", busy, 1);
    #1 Reset_n = 1'b0; #1;
    model_reset();
    chk("rst_busy", busy, 0);
    chk("rst_zero_flag", zero_flag, 0);
    chk("rst_rd_valid", rd_valid, 0);
    @(negedge Sclk); Reset_n = 1'b1;
    for (int i = 0; i < 400; i++) step(1, 0, 16'h0, 0, 0, 8'd0, 0);
    chk("rst_zcnt_cleared", zero_flag[0], 0);
    step(1, 0, 16'hABCD, 0, 0, 8'd0, 0);
    step(0, 0, 16'h0, 1, 0, 8'd0, 0);
    chk("rst_write_off0", rd_data, 16'hABCD);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_data_buffer.md
MC_DATA_BUFFER -- requirements
Module: mc_data_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning sample width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning per-channel depth of 2**ADDR_W samples.
REQ-003 SHALL have parameter NUM_CH, default 2, meaning number of independent channels (L/R); CH_W = max(1, clog2(NUM_CH)).
REQ-004 SHALL have parameter ZERO_LIMIT, default 800, meaning consecutive zero samples before zero flag asserts; CNT_W = clog2(ZERO_LIMIT+1).
REQ-005 SHALL have port Sclk, input, 1, meaning the single system clock; all state changes on posedge.
REQ-006 SHALL have port Reset_n, input, 1, meaning asynchronous active-low reset.
REQ-007 SHALL have port clr_req, input, 1, meaning a one-cycle pulse that starts a memory clear sweep.
REQ-008 SHALL have port wr_en, input, 1, meaning write one sample.
REQ-009 SHALL have port wr_ch, input, CH_W, meaning target channel of the write.
REQ-010 SHALL have port data_in, input, DATA_W, meaning the sample to write.
REQ-011 SHALL have port rd_en, input, 1, meaning read request.
REQ-012 SHALL have port rd_ch, input, CH_W, meaning channel to read.
REQ-013 SHALL have port rd_offset, input, ADDR_W, meaning age of the sample to read: 0 = newest, k = x[n-k].
REQ-014 SHALL have port rd_data, output, DATA_W, meaning the registered read sample.
REQ-015 SHALL have port rd_valid, output, 1, meaning rd_data valid this cycle.
REQ-016 SHALL have port busy, output, 1, meaning a clear sweep is in progress.
REQ-017 SHALL have port wr_drop, output, 1, meaning a one-cycle pulse when a write was discarded.
REQ-018 SHALL have port zero_flag, output, NUM_CH, meaning per-channel sustained-zero indication.

Function
REQ-019 Each channel SHALL own a DEPTH-entry circular bank and a write pointer wr_ptr[ch] of ADDR_W bits.
REQ-020 A write with busy=0 SHALL store data_in at bank[wr_ch][wr_ptr] and increment wr_ptr modulo DEPTH (wrap DEPTH-1 -> 0, oldest sample overwritten).
REQ-021 Read address SHALL be (wr_ptr[rd_ch] - 1 - rd_offset) mod DEPTH; read latency SHALL be 1 cycle: rd_valid = rd_en delayed one cycle, rd_data valid with it.
REQ-022 When rd_valid=0, rd_data SHALL be 0.
REQ-023 Simultaneous read and write to the same channel SHALL use the pre-write wr_ptr and pre-write memory contents (read-before-write).
REQ-024 wr_ch or rd_ch >= NUM_CH SHALL be ignored: a write pulses wr_drop, and a read returns 0 with rd_valid=1.
REQ-025 The FSM SHALL have states IDLE and CLEAR; IDLE->CLEAR on clr_req; CLEAR writes 0 to address clr_addr in all banks each cycle, clr_addr counting 0..DEPTH-1; CLEAR->IDLE after address DEPTH-1, so CLEAR lasts exactly DEPTH cycles.
REQ-026 Entering CLEAR SHALL reset all wr_ptr to 0; busy SHALL be 1 exactly while in CLEAR.
REQ-027 clr_req during CLEAR SHALL restart the sweep at address 0.
REQ-028 A write during CLEAR SHALL be discarded and pulse wr_drop the next cycle; a read during CLEAR SHALL return 0 with rd_valid.
REQ-029 The zero detector SHALL evaluate per accepted write: data_in==0 increments zero_cnt[wr_ch], saturating at ZERO_LIMIT; a nonzero sample clears zero_cnt[wr_ch] and zero_flag[wr_ch].
REQ-030 zero_flag[ch] SHALL assert in the cycle after the write that brings zero_cnt to ZERO_LIMIT, and SHALL stay asserted while further zeros arrive.
REQ-031 A clear sweep SHALL NOT alter zero_cnt or zero_flag.

Reset
REQ-032 On Reset_n=0, the block SHALL asynchronously enter IDLE with wr_ptr=0, zero_cnt=0, rd_data=0, rd_valid=0, busy=0, wr_drop=0, and zero_flag=0.
REQ-033 Memory contents SHALL NOT be reset; software issues clr_req after reset.
REQ-034 Reset asserted mid-CLEAR SHALL abort the sweep, and busy SHALL fall immediately.

Configuration
REQ-035 With macro MC_DBUF_ZERO_DETECT_EN defined, REQ-029 to REQ-031 SHALL apply; when undefined, no zero counters SHALL be built and zero_flag SHALL be constant 0.

Structure
REQ-036 Package mc_dbuf_pkg SHALL hold the FSM state enum (IDLE, CLEAR) and the default constants for DATA_W, ADDR_W, NUM_CH, and ZERO_LIMIT.
REQ-037 One sub-module, dbuf_bank, SHALL implement a single-channel single-port-write/registered-read DEPTH x DATA_W bank, instantiated NUM_CH times.

Verification
REQ-038 Write 1..5 to ch0, then read offset 0,1,4 -> rd_data 5,4,1, each one cycle after rd_en.
REQ-039 Write 260 samples (value=index) to ch1 at ADDR_W=8, then read offset 0 -> 259 and offset 255 -> 4 (wrap verified).
REQ-040 Write 7 to ch0 with simultaneous read offset 0 of ch0 when the newest sample is 3 -> rd_data 3.
REQ-041 clr_req, then writes on cycles 1 and 100 -> busy high for exactly 256 cycles, wr_drop pulses twice, and all reads afterwards return 0.
REQ-042 Write 800 zeros to ch0 -> zero_flag[0] rises after the 800th write; then write 1 -> flag clears next cycle; zero_flag[1] stays 0 throughout.
REQ-043 Assert Reset_n low mid-CLEAR and mid-zero-count -> busy, zero_flag, and rd_valid are 0 immediately, and the next write lands at offset 0.
